// File: rtl/time_keeper_pkg.sv
// Shared types and constants for the time-of-day core: set-mode states,
// BCD field limits, per-state digit edit masks and BCD increment helpers.
package time_keeper_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } tk_state_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] SEC_MAX  = 8'h59;

    localparam logic [5:0] MASK_RUN = 6'b000000;
    localparam logic [5:0] MASK_HR  = 6'b110000;
    localparam logic [5:0] MASK_MIN = 6'b001100;
    localparam logic [5:0] MASK_SEC = 6'b000011;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_next(input logic [7:0] value, input logic [7:0] max);
        logic [7:0] res;
        if (value == max) begin
            res = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            res = {value[7:4] + 4'd1, 4'd0};
        end else begin
            res = {value[7:4], value[3:0] + 4'd1};
        end
        return res;
    endfunction

    function automatic tk_state_t next_mode(input tk_state_t s);
        tk_state_t n;
        case (s)
            ST_RUN:     n = ST_SET_HR;
            ST_SET_HR:  n = ST_SET_MIN;
            ST_SET_MIN: n = ST_SET_SEC;
            ST_SET_SEC: n = ST_RUN;
            default:    n = ST_RUN;
        endcase
        return n;
    endfunction

    function automatic logic [5:0] edit_mask_of(input tk_state_t s);
        logic [5:0] m;
        case (s)
            ST_RUN:     m = MASK_RUN;
            ST_SET_HR:  m = MASK_HR;
            ST_SET_MIN: m = MASK_MIN;
            ST_SET_SEC: m = MASK_SEC;
            default:    m = MASK_RUN;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/time_keeper_bcd_field_counter.sv
// Two-digit BCD field register counting 00..MAX; wrap flags the increment
// that rolls the field back to 00 so it can feed the next field's carry.
module bcd_field_counter
    import time_keeper_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] value,
    output logic       wrap
);

    logic [7:0] value_r;

    // Field register: clear dominates, otherwise step on inc.
    always_ff @(posedge clk) begin
        if (clr) begin
            value_r <= 8'h00;
        end else if (inc) begin
            value_r <= bcd_next(value_r, MAX);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
    assign wrap  = inc && (value_r == MAX);

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day keeper: per-second prescaler, carry chain across
// hour/minute/second fields, and a button-driven set mode with edit masks.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [23:0] currentTime,
    output logic [5:0]  edit_mask,
    output logic        sec_tick,
    output logic        day_pulse
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    tk_state_t   state_r;
    logic [PW-1:0] presc_r;
    logic [5:0]  edit_mask_r;
    logic        sec_tick_r;
    logic        day_pulse_r;

    logic        run_s;
    logic        terminal_s;
    logic        edit_inc_s;
    logic        sec_inc_s;
    logic        min_inc_s;
    logic        hr_inc_s;
    logic        sec_wrap_s;
    logic        min_wrap_s;
    logic        hr_wrap_s;
    logic [7:0]  sec_val_s;
    logic [7:0]  min_val_s;
    logic [7:0]  hr_val_s;

    assign run_s      = (state_r == ST_RUN);
    assign terminal_s = run_s && (presc_r == PRESC_LAST);
    // A simultaneous mode step swallows the increment.
    assign edit_inc_s = btn_inc && !btn_mode;

    assign sec_inc_s = run_s ? terminal_s
                             : (edit_inc_s && (state_r == ST_SET_SEC));
    assign min_inc_s = run_s ? (terminal_s && sec_wrap_s)
                             : (edit_inc_s && (state_r == ST_SET_MIN));
    assign hr_inc_s  = run_s ? (terminal_s && sec_wrap_s && min_wrap_s)
                             : (edit_inc_s && (state_r == ST_SET_HR));

    bcd_field_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .clr   (CLR),
        .inc   (sec_inc_s),
        .value (sec_val_s),
        .wrap  (sec_wrap_s)
    );

    bcd_field_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .clr   (CLR),
        .inc   (min_inc_s),
        .value (min_val_s),
        .wrap  (min_wrap_s)
    );

    bcd_field_counter #(.MAX(HOUR_MAX)) u_hr (
        .clk   (clk),
        .clr   (CLR),
        .inc   (hr_inc_s),
        .value (hr_val_s),
        .wrap  (hr_wrap_s)
    );

    // Prescaler: counts only while running and parks at zero on leaving RUN.
    always_ff @(posedge clk) begin
        if (CLR) begin
            presc_r <= PW'(0);
        end else if (!run_s || btn_mode || terminal_s) begin
            presc_r <= PW'(0);
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Mode state machine with registered mask and second/day pulses.
    always_ff @(posedge clk) begin
        if (CLR) begin
            state_r     <= ST_RUN;
            edit_mask_r <= MASK_RUN;
            sec_tick_r  <= 1'b0;
            day_pulse_r <= 1'b0;
        end else begin
            sec_tick_r  <= terminal_s;
            day_pulse_r <= terminal_s && hr_wrap_s;
            if (btn_mode) begin
                state_r     <= next_mode(state_r);
                edit_mask_r <= edit_mask_of(next_mode(state_r));
            end else begin
                state_r     <= state_r;
                edit_mask_r <= edit_mask_r;
            end
        end
    end

    assign currentTime = {hr_val_s, min_val_s, sec_val_s};
    assign edit_mask   = edit_mask_r;
    assign sec_tick    = sec_tick_r;
    assign day_pulse   = day_pulse_r;

endmodule

// File: tb/tb_time_keeper.sv
// Randomized and directed bench for time_keeper; the reference keeps time as
// seconds-of-day plus a mode index and a cycles-into-second count.
module tb_time_keeper;

    localparam int TD = 4;

    logic        clk;
    logic        CLR;
    logic        btn_mode;
    logic        btn_inc;
    logic [23:0] currentTime;
    logic [5:0]  edit_mask;
    logic        sec_tick;
    logic        day_pulse;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // reference model state
    int m_tod  = 0;
    int m_mode = 0;
    int m_cnt  = 0;
    bit m_tick = 1'b0;
    bit m_day  = 1'b0;

    time_keeper #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .CLR         (CLR),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .currentTime (currentTime),
        .edit_mask   (edit_mask),
        .sec_tick    (sec_tick),
        .day_pulse   (day_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int tod);
        int h, m, s;
        h = tod / 3600;
        m = (tod / 60) % 60;
        s = tod % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [5:0] mask_for(input int mode);
        case (mode)
            1:       return 6'b110000;
            2:       return 6'b001100;
            3:       return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit c, input bit m, input bit i);
        int h, mi, s;
        if (c) begin
            m_tod = 0; m_mode = 0; m_cnt = 0; m_tick = 1'b0; m_day = 1'b0;
        end else begin
            m_tick = 1'b0;
            m_day  = 1'b0;
            if (m_mode == 0) begin
                if (m_cnt == TD - 1) begin
                    m_tod  = (m_tod + 1) % 86400;
                    m_tick = 1'b1;
                    m_day  = (m_tod == 0);
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else if (i && !m) begin
                h  = m_tod / 3600;
                mi = (m_tod / 60) % 60;
                s  = m_tod % 60;
                if (m_mode == 1) h = (h + 1) % 24;
                if (m_mode == 2) mi = (mi + 1) % 60;
                if (m_mode == 3) s = (s + 1) % 60;
                m_tod = h * 3600 + mi * 60 + s;
            end
            if (m) begin
                m_mode = (m_mode + 1) % 4;
                m_cnt  = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic step(input bit c, input bit m, input bit i);
        CLR = c; btn_mode = m; btn_inc = i;
        @(posedge clk);
        model_step(c, m, i);
        @(negedge clk);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        step(1'b0, 1'b1, 1'b0);
        repeat (h) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (m) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (s) step(1'b0, 1'b0, 1'b1);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("time", 32'(currentTime), 32'(to_bcd(m_tod)));
            chk("edit_mask", 32'(edit_mask), 32'(mask_for(m_mode)));
            chk("sec_tick", 32'(sec_tick), 32'(m_tick));
            chk("day_pulse", 32'(day_pulse), 32'(m_day));
        end
    end

    initial begin
        CLR = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        @(negedge clk);

        // reset and release
        step(1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk("rst_time", 32'(currentTime), 32'h000000);
        chk("rst_mask", 32'(edit_mask), 32'h00);
        chk("rst_tick", 32'(sec_tick), 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("pre_first_tick", 32'(sec_tick), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("first_tick", 32'(sec_tick), 32'h1);
        chk("first_tick_time", 32'(currentTime), 32'h000001);

        // set hours: 25 increments from 00 wrap to 01
        step(1'b0, 1'b1, 1'b0);
        chk("sethr_mask", 32'(edit_mask), 32'b110000);
        repeat (25) step(1'b0, 1'b0, 1'b1);
        chk("sethr_time", 32'(currentTime), 32'h010001);

        // seconds wrap without carry
        step(1'b1, 1'b0, 1'b0);
        set_time(12, 34, 59);
        chk("set_123459", 32'(currentTime), 32'h123459);
        step(1'b0, 1'b0, 1'b1);
        chk("sec_wrap_nocarry", 32'(currentTime), 32'h123400);

        // mode + inc together in SET_MIN
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("in_setmin_mask", 32'(edit_mask), 32'b001100);
        step(1'b0, 1'b1, 1'b1);
        chk("simul_mask", 32'(edit_mask), 32'b000011);
        chk("simul_time", 32'(currentTime), 32'h123400);

        // reset mid-edit
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("midedit_time", 32'(currentTime), 32'h000000);
        chk("midedit_mask", 32'(edit_mask), 32'h00);

        // day rollover
        set_time(23, 59, 58);
        step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("roll_235959", 32'(currentTime), 32'h235959);
        chk("roll_day_early", 32'(day_pulse), 32'h0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("roll_000000", 32'(currentTime), 32'h000000);
        chk("roll_tick", 32'(sec_tick), 32'h1);
        chk("roll_day", 32'(day_pulse), 32'h1);

        // mode press on the terminal prescaler cycle
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("term_mode_time", 32'(currentTime), 32'h000001);
        chk("term_mode_mask", 32'(edit_mask), 32'b110000);
        chk("term_mode_day", 32'(day_pulse), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("term_mode_tick_gone", 32'(sec_tick), 32'h0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(2) == 0);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
